wc_store_buffer: RTL and testbench

WC_STORE_BUFFER -- requirements
Module: wc_store_buffer

---
 rtl/wc_store_buffer_pkg.sv | 24 ++
 rtl/wc_store_buffer_addr_cam.sv | 54 +++++
 rtl/wc_store_buffer.sv | 137 +++++++++++++
 tb/tb_wc_store_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wc_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// wc_store_buffer_pkg
// Shared types for the write-combining store buffer:
//   retire_store_t : store handed over by ROB retire (ready flag, address, data)
//   wc_array_t     : one buffer entry (data, word address, valid)
//   WB_DEPTH       : default number of buffer entries
// -----------------------------------------------------------------------------
package wc_store_buffer_pkg;

    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic        store_ready;
        logic [31:0] mem_address;
        logic [31:0] retire_rs2_data;
    } retire_store_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] address;
        logic        valid;
    } wc_array_t;

endpackage

// File: rtl/wc_store_buffer_addr_cam.sv
// -----------------------------------------------------------------------------
// wb_addr_cam
// Word-address match and priority logic for the store buffer.
// Ports:
//   entries_i    : all buffer entries, indexed by physical slot
//   head_i       : slot of the oldest entry
//   excl_head_i  : head is being written to memory, so it may not be combined into
//   ld_addr_i    : load address for forwarding lookup
//   st_addr_i    : retiring store address for combine lookup
//   ld_hit_o / ld_idx_o   : youngest valid match for the load (head included)
//   cmb_hit_o / cmb_idx_o : youngest valid match for the store (head optionally excluded)
// -----------------------------------------------------------------------------
module wb_addr_cam
    import wc_store_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wc_array_t [DEPTH-1:0] entries_i,
    input  logic [PW-1:0]         head_i,
    input  logic                  excl_head_i,
    input  logic [31:0]           ld_addr_i,
    input  logic [31:0]           st_addr_i,
    output logic                  ld_hit_o,
    output logic [PW-1:0]         ld_idx_o,
    output logic                  cmb_hit_o,
    output logic [PW-1:0]         cmb_idx_o
);

    logic [PW-1:0] idx;

    // Walk slots from oldest to youngest; the last match seen is the youngest.
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_idx_o  = '0;
        cmb_hit_o = 1'b0;
        cmb_idx_o = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (entries_i[idx].valid &&
                entries_i[idx].address[31:2] == ld_addr_i[31:2]) begin
                ld_hit_o = 1'b1;
                ld_idx_o = idx;
            end
            if (entries_i[idx].valid && !(excl_head_i && (k == 0)) &&
                entries_i[idx].address[31:2] == st_addr_i[31:2]) begin
                cmb_hit_o = 1'b1;
                cmb_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/wc_store_buffer.sv
// -----------------------------------------------------------------------------
// wc_store_buffer
// Write-combining store buffer between ROB retire and data memory. Retired
// stores either merge into a resident non-draining entry with the same word
// address or allocate a new entry at the tail; the head entry is written out
// to memory and retired on mem_ack. Loads can forward from the youngest
// matching entry.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   retire_st       : store from ROB retire (store_ready, mem_address, data)
//   store_executed  : store accepted this cycle (combined or allocated)
//   mem_wr_en/addr/wdata, mem_ack : memory write handshake from the head entry
//   ld_addr, ld_hit, ld_data      : load forwarding lookup
//   wb_empty        : buffer holds no valid entries
// -----------------------------------------------------------------------------
module wc_store_buffer
    import wc_store_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  retire_store_t retire_st,
    output logic          store_executed,
    output logic          mem_wr_en,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   ld_addr,
    output logic          ld_hit,
    output logic [31:0]   ld_data,
    output logic          wb_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]        vld_q,  vld_d;
    logic [DEPTH-1:0][31:0]  addr_q, addr_d;
    logic [DEPTH-1:0][31:0]  data_q, data_d;
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;

    wc_array_t [DEPTH-1:0]   entries;
    logic                    cam_ld_hit, cam_cmb_hit;
    logic [PW-1:0]           cam_ld_idx, cam_cmb_idx;
    logic                    full, cmb, alloc, drain;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i].data    = data_q[i];
            entries[i].address = addr_q[i];
            entries[i].valid   = vld_q[i];
        end
    end

    // The head is excluded from combining while it is being written so the
    // memory sees stable data until it acknowledges.
    wb_addr_cam #(.DEPTH(DEPTH), .PW(PW)) u_cam (
        .entries_i   (entries),
        .head_i      (head_q),
        .excl_head_i (mem_wr_en),
        .ld_addr_i   (ld_addr),
        .st_addr_i   (retire_st.mem_address),
        .ld_hit_o    (cam_ld_hit),
        .ld_idx_o    (cam_ld_idx),
        .cmb_hit_o   (cam_cmb_hit),
        .cmb_idx_o   (cam_cmb_idx)
    );

    assign full      = (count_q == CW'(DEPTH));
    assign mem_wr_en = vld_q[head_q];
    assign drain     = mem_wr_en && mem_ack;
    assign cmb       = retire_st.store_ready && cam_cmb_hit;
    // A slot freed by a same-cycle drain is not reusable until the next cycle.
    assign alloc     = retire_st.store_ready && !cam_cmb_hit && !full;

    // Reset drops everything, so a store presented during reset is not accepted.
    assign store_executed = !rst && (cmb || alloc);

    // Outputs are zero-gated so they read 0 when nothing is valid, without
    // having to reset the data storage.
    assign mem_addr  = mem_wr_en ? addr_q[head_q] : 32'h0;
    assign mem_wdata = mem_wr_en ? data_q[head_q] : 32'h0;
    assign ld_hit    = cam_ld_hit;
    assign ld_data   = cam_ld_hit ? data_q[cam_ld_idx] : 32'h0;
    assign wb_empty  = (count_q == '0);

    always_comb begin
        vld_d   = vld_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (cmb) begin
            data_d[cam_cmb_idx] = retire_st.retire_rs2_data;
        end
        if (drain) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        // Tail never equals a draining head here: that would require a full buffer.
        if (alloc) begin
            vld_d[tail_q]  = 1'b1;
            addr_d[tail_q] = {retire_st.mem_address[31:2], 2'b00};
            data_d[tail_q] = retire_st.retire_rs2_data;
            tail_d         = tail_q + PW'(1);
        end
        case ({alloc, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_wc_store_buffer.sv
module tb_wc_store_buffer;
    import wc_store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    retire_store_t retire_st;
    logic          store_executed;
    logic          mem_wr_en;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   ld_addr;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          wb_empty;

    int tests = 0;
    int fails = 0;

    // Reference model: committed stores, oldest first.
    logic [31:0] qa[$];
    logic [31:0] qd[$];

    wc_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .retire_st      (retire_st),
        .store_executed (store_executed),
        .mem_wr_en      (mem_wr_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .ld_addr        (ld_addr),
        .ld_hit         (ld_hit),
        .ld_data        (ld_data),
        .wb_empty       (wb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: apply inputs, check combinational outputs against the
    // model's view of the current state, then advance the model with the edge.
    task automatic step(input logic sr, input logic [31:0] a, input logic [31:0] d,
                        input logic ack, input logic [31:0] la);
        int n, cj, lj;
        logic full, exp_se;
        @(negedge clk);
        retire_st.store_ready     = sr;
        retire_st.mem_address     = a;
        retire_st.retire_rs2_data = d;
        mem_ack = ack;
        ld_addr = la;
        #1;
        n  = qa.size();
        cj = -1;
        lj = -1;
        // While non-empty, the oldest entry is being written and can't be merged into.
        for (int j = 1; j < n; j++)
            if (qa[j][31:2] == a[31:2]) cj = j;
        for (int j = 0; j < n; j++)
            if (qa[j][31:2] == la[31:2]) lj = j;
        full   = (n == DEPTH);
        exp_se = sr && ((cj >= 0) || !full);
        check("store_executed", {31'b0, store_executed}, {31'b0, exp_se});
        check("mem_wr_en",      {31'b0, mem_wr_en},      {31'b0, n > 0});
        check("mem_addr",       mem_addr,  (n > 0) ? qa[0] : 32'h0);
        check("mem_wdata",      mem_wdata, (n > 0) ? qd[0] : 32'h0);
        check("ld_hit",         {31'b0, ld_hit},         {31'b0, lj >= 0});
        check("ld_data",        ld_data,   (lj >= 0) ? qd[lj] : 32'h0);
        check("wb_empty",       {31'b0, wb_empty},       {31'b0, n == 0});
        @(posedge clk);
        if (sr && cj >= 0) qd[cj] = d;
        if (ack && n > 0) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        if (sr && cj < 0 && !full) begin
            qa.push_back({a[31:2], 2'b00});
            qd.push_back(d);
        end
    endtask

    task automatic do_reset(input logic ack);
        @(negedge clk);
        rst = 1'b1;
        retire_st.store_ready     = 1'b1;
        retire_st.mem_address     = 32'h500;
        retire_st.retire_rs2_data = 32'hDEAD;
        mem_ack = ack;
        @(posedge clk);
        #1;
        rst = 1'b0;
        retire_st.store_ready = 1'b0;
        mem_ack = 1'b0;
        qa.delete();
        qd.delete();
    endtask

    initial begin
        rst       = 1'b0;
        retire_st = '0;
        mem_ack   = 1'b0;
        ld_addr   = 32'h0;

        // Reset state
        do_reset(1'b0);
        step(0, 32'h0, 32'h0, 0, 32'h0);
        check("rst_wb_empty", {31'b0, wb_empty}, 32'h1);
        check("rst_mem_addr", mem_addr, 32'h0);

        // Single store, then visible at head the next cycle
        step(1, 32'h100, 32'hAAAA, 0, 32'h0);
        step(0, 32'h0, 32'h0, 0, 32'h0);
        check("drain_addr", mem_addr, 32'h100);
        check("drain_data", mem_wdata, 32'hAAAA);

        // Combining behind a pending head
        step(1, 32'h200, 32'h1, 0, 32'h0);
        step(1, 32'h200, 32'h2, 0, 32'h0);
        step(0, 32'h0, 32'h0, 0, 32'h200);
        check("cmb_ld_data", ld_data, 32'h2);
        check("cmb_head_hold", mem_wdata, 32'hAAAA);
        step(0, 32'h0, 32'h0, 1, 32'h0);
        step(0, 32'h0, 32'h0, 1, 32'h0);
        step(0, 32'h0, 32'h0, 0, 32'h0);

        // Full buffer: reject new, combine into non-head
        do_reset(1'b0);
        step(1, 32'h100, 32'h10, 0, 32'h0);
        step(1, 32'h104, 32'h11, 0, 32'h0);
        step(1, 32'h108, 32'h12, 0, 32'h0);
        step(1, 32'h10C, 32'h13, 0, 32'h0);
        step(1, 32'h300, 32'h77, 0, 32'h0);
        check("full_reject", {31'b0, store_executed}, 32'h0);
        step(1, 32'h108, 32'h55, 0, 32'h108);
        check("full_combine", {31'b0, store_executed}, 32'h1);
        step(0, 32'h0, 32'h0, 0, 32'h108);
        check("full_combine_data", ld_data, 32'h55);

        // Full with ack and store same cycle: not accepted until next cycle
        step(1, 32'h300, 32'h7, 1, 32'h0);
        check("full_ack_reject", {31'b0, store_executed}, 32'h0);
        step(1, 32'h300, 32'h7, 0, 32'h300);
        check("after_ack_accept", {31'b0, store_executed}, 32'h1);
        step(1, 32'h400, 32'h8, 0, 32'h300);
        check("refull_reject", {31'b0, store_executed}, 32'h0);

        // Forwarding from the youngest of two same-word entries
        do_reset(1'b0);
        step(1, 32'h104, 32'h5, 0, 32'h0);
        step(1, 32'h104, 32'h9, 0, 32'h0);
        step(0, 32'h0, 32'h0, 0, 32'h106);
        check("fwd_youngest", ld_data, 32'h9);
        step(0, 32'h0, 32'h0, 0, 32'h400);
        check("fwd_miss", {31'b0, ld_hit}, 32'h0);

        // Reset mid-transaction abandons pending writes
        step(1, 32'h108, 32'h1, 0, 32'h0);
        step(0, 32'h0, 32'h0, 0, 32'h0);
        check("pre_rst_wr_en", {31'b0, mem_wr_en}, 32'h1);
        do_reset(1'b1);
        step(0, 32'h0, 32'h0, 1, 32'h104);
        check("post_rst_empty", {31'b0, wb_empty}, 32'h1);
        check("post_rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
        step(0, 32'h0, 32'h0, 1, 32'h0);

        // Randomized traffic over a small address pool to force combining
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 9) < 7,
                     32'h100 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3)),
                     $urandom,
                     $urandom_range(0, 1) == 1,
                     32'h100 + 32'($urandom_range(0, 6)) * 4 + 32'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
